// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 word demultiplexer.
package demux_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NCH_DEF   = 4;

  typedef logic [1:0]           ch_sel_t;
  typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot: a valid bit (EMPTY/FULL) plus a data register.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_drain,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A load wins over a drain on the same edge, so a full slot refills without a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/demux4_buf16.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ready slot per channel.
// Define DEMUX4_BCAST_EN to add the in_bcast port (load all four slots at once).
module demux4_buf16
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH   = NCH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_data,
  input  ch_sel_t              control,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready
`ifdef DEMUX4_BCAST_EN
  ,
  input  logic                 in_bcast
`endif
);

  logic [NCH-1:0] w_slotFree;
  logic [NCH-1:0] w_target;
  logic [NCH-1:0] w_load;
  logic           w_accept;

  // A slot can take a word if it is empty or is being drained on this edge.
  assign w_slotFree = ~out_valid | out_ready;

  always_comb begin
    w_target          = '0;
    w_target[control] = 1'b1;
    in_ready          = w_slotFree[control];
`ifdef DEMUX4_BCAST_EN
    if (in_bcast) begin
      w_target = '1;
      in_ready = &w_slotFree;
    end
`endif
  end

  assign w_accept = in_valid & in_ready;
  assign w_load   = {NCH{w_accept}} & w_target;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clock  (clock),
      .reset  (reset),
      .i_load (w_load[k]),
      .i_data (in_data),
      .i_drain(out_ready[k]),
      .o_valid(out_valid[k]),
      .o_data (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux4_buf16.sv
// Self-checking bench for demux4_buf16: directed scenarios plus randomized traffic
// against a slot-array reference model. Define DEMUX4_BCAST_EN for the broadcast build.
module tb_demux4_buf16;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic [1:0]  control;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
`ifdef DEMUX4_BCAST_EN
  logic        in_bcast;
`endif

  int checks   = 0;
  int failures = 0;

  logic        mValid[4];
  logic [15:0] mData[4];
  logic        lastAccept;

  demux4_buf16 dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .control  (control),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DEMUX4_BCAST_EN
    ,
    .in_bcast (in_bcast)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic bcastNow();
`ifdef DEMUX4_BCAST_EN
    return in_bcast;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic modelReady();
    logic r;
    if (bcastNow()) begin
      r = 1'b1;
      for (int k = 0; k < 4; k++) r = r && (!mValid[k] || out_ready[k]);
    end else begin
      r = !mValid[control] || out_ready[control];
    end
    return r;
  endfunction

  function automatic logic [3:0] modelValid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = mValid[k];
    return v;
  endfunction

  function automatic logic [63:0] modelBus();
    logic [63:0] b;
    for (int k = 0; k < 4; k++) b[k*16 +: 16] = mData[k];
    return b;
  endfunction

  // Reference model advances on each rising edge from the inputs the bench holds there.
  task automatic advance();
    logic acc;
    logic bc;
    @(posedge clock);
    bc  = bcastNow();
    acc = in_valid && modelReady();
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        mValid[k] = 1'b0;
        mData[k]  = 16'h0000;
      end
      lastAccept = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acc && (bc || control == k[1:0])) begin
          mValid[k] = 1'b1;
          mData[k]  = in_data;
        end else if (mValid[k] && out_ready[k]) begin
          mValid[k] = 1'b0;
        end
      end
      lastAccept = acc;
    end
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] c);
    in_data  = d;
    control  = c;
    in_valid = 1'b1;
  endtask

  // Producer contract: a pending word and its select stay put until accepted.
  logic        pHold = 1'b0;
  logic [15:0] pData;
  logic [1:0]  pCtl;
  always @(posedge clock) begin
    if (pHold && !reset)
      assert (in_data === pData && control === pCtl)
        else $error("[TB] producer changed a pending word");
    pHold <= in_valid && !in_ready && !reset;
    pData <= in_data;
    pCtl  <= control;
  end

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    control   = 2'd0;
    out_ready = 4'b0000;
`ifdef DEMUX4_BCAST_EN
    in_bcast  = 1'b0;
`endif
    advance();
    advance();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_valid got=%b exp=0000", out_valid);
    end
    checks++;
    if (out_data !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h exp=0", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready got=%b exp=1", in_ready);
    end
    advance();
  endtask

  task automatic test_unicast();
    out_ready = 4'b1111;
    send(16'h1234, 2'd2);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL uni_ready got=%b exp=1", in_ready);
    end
    advance();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL uni_valid got=%b exp=0100", out_valid);
    end
    checks++;
    if (out_data[47:32] !== 16'h1234) begin
      failures++;
      $display("[TB] FAIL uni_data got=%h exp=1234", out_data[47:32]);
    end
    advance();
    @(negedge clock);
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL uni_drain got=%b exp=0000", out_valid);
    end
    advance();
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101;
    send(16'hAAAA, 2'd1);
    advance();
    send(16'hBBBB, 2'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_ready_low got=%b exp=0", in_ready);
      end
      checks++;
      if (out_valid !== 4'b0010 || out_data[31:16] !== 16'hAAAA) begin
        failures++;
        $display("[TB] FAIL bp_hold got=%b/%h exp=0010/aaaa", out_valid, out_data[31:16]);
      end
      advance();
    end
    out_ready = 4'b1111;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release got=%b exp=1", in_ready);
    end
    advance();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 4'b0010 || out_data[31:16] !== 16'hBBBB) begin
      failures++;
      $display("[TB] FAIL bp_no_bubble got=%b/%h exp=0010/bbbb", out_valid, out_data[31:16]);
    end
    advance();
    @(negedge clock);
    checks++;
    if (out_valid !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL bp_drain got=%b exp=0000", out_valid);
    end
  endtask

  task automatic test_independent();
    out_ready = 4'b1110;
    send(16'h0001, 2'd0);
    advance();
    send(16'h0003, 2'd3);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ind_ready got=%b exp=1", in_ready);
    end
    advance();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 4'b1001 || out_data[63:48] !== 16'h0003 || out_data[15:0] !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL ind_both got=%b/%h exp=1001/0003..0001", out_valid, out_data);
    end
    advance();
    @(negedge clock);
    checks++;
    if (out_valid !== 4'b0001 || out_data[15:0] !== 16'h0001) begin
      failures++;
      $display("[TB] FAIL ind_ch0_held got=%b/%h exp=0001/0001", out_valid, out_data[15:0]);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b0110;
    send(16'h0777, 2'd3);
    advance();
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL rmid_setup got=%b exp=1001", out_valid);
    end
    out_ready = 4'b0000;
    reset     = 1'b1;
    send(16'hDEAD, 2'd2);
    advance();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 64'h0) begin
      failures++;
      $display("[TB] FAIL rmid_clear got=%b/%h exp=0000/0", out_valid, out_data);
    end
    advance();
  endtask

`ifdef DEMUX4_BCAST_EN
  task automatic test_bcast();
    out_ready = 4'b1011;
    send(16'h2222, 2'd2);
    advance();
    in_bcast = 1'b1;
    send(16'h5A5A, 2'd0);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bc_stall got=%b exp=0", in_ready);
    end
    advance();
    out_ready = 4'b1111;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bc_release got=%b exp=1", in_ready);
    end
    advance();
    in_valid = 1'b0;
    in_bcast = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 4'b1111 || out_data !== {4{16'h5A5A}}) begin
      failures++;
      $display("[TB] FAIL bc_all got=%b/%h exp=1111/5a5a x4", out_valid, out_data);
    end
    advance();
  endtask
`endif

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      out_ready = 4'($urandom_range(0, 15));
      reset     = ($urandom_range(0, 49) == 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = 16'($urandom);
        control  = 2'($urandom_range(0, 3));
`ifdef DEMUX4_BCAST_EN
        in_bcast = ($urandom_range(0, 3) == 0);
`endif
      end
      @(negedge clock);
      checks++;
      if (in_ready !== modelReady()) begin
        failures++;
        $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready, modelReady());
      end
      checks++;
      if (out_valid !== modelValid()) begin
        failures++;
        $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, modelValid());
      end
      checks++;
      if (out_data !== modelBus()) begin
        failures++;
        $display("[TB] FAIL rnd_data cyc=%0d got=%h exp=%h", i, out_data, modelBus());
      end
      advance();
      hold = in_valid && !lastAccept;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      mValid[k] = 1'b0;
      mData[k]  = 16'h0;
    end
    lastAccept = 1'b0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_independent();
    test_reset_mid();
`ifdef DEMUX4_BCAST_EN
    test_bcast();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
